// File: rtl/pgm_rom_line_cache.sv
// Direct-mapped 64-bit line cache for the 68k BIOS/P-ROM window, filled from the DDRAM arbiter over a four-phase req/ack.
// Optional macro PGM_ROMCACHE_STATS_EN adds saturating hit/miss counters (stat_hits, stat_misses).
module pgm_rom_line_cache #(
    parameter int LINES_LOG2 = 6,
    parameter int TAG_W      = 21 - LINES_LOG2
) (
    input  logic        fixed_20m_clk,
    input  logic        reset,
    input  logic        cpu_sel,
    input  logic        cpu_rw,
    input  logic [22:0] cpu_addr,
    output logic [15:0] cpu_dout,
    output logic        cpu_dtack_n,
    input  logic        flush,
    output logic        mem_req,
    output logic [20:0] mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_data,
    output logic        busy,
    output logic [2:0]  dbg_state_o
`ifdef PGM_ROMCACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);

    localparam int LINES = 1 << LINES_LOG2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_REQ    = 3'd2,
        ST_REL    = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic                  sel_q;
    logic                  ack_meta_q;
    logic                  ack_s_q;
    logic [22:0]           addr_q, addr_d;
    logic                  flush_seen_q, flush_seen_d;
    logic [15:0]           dout_q, dout_d;
    logic                  dtack_n_q, dtack_n_d;
    logic                  req_q, req_d;
    logic [20:0]           mem_addr_q, mem_addr_d;
    logic                  busy_q, busy_d;
    logic [LINES-1:0]      valid_q;

    logic [63:0]           data_mem [LINES];
    logic [TAG_W-1:0]      tag_mem  [LINES];

    logic [LINES_LOG2-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [1:0]            word;
    logic [20:0]           line_addr;
    logic                  sel_rise;
    logic                  hit;
    logic                  fill_we;
    logic                  fill_keep;

    function automatic logic [15:0] pick_word(input logic [63:0] line, input logic [1:0] w);
        return line[{w, 4'b0000} +: 16];
    endfunction

    assign idx       = addr_q[LINES_LOG2+1:2];
    assign tag       = addr_q[22:LINES_LOG2+2];
    assign word      = addr_q[1:0];
    assign line_addr = addr_q[22:2];
    assign sel_rise  = cpu_sel && !sel_q;
    // A flush in the lookup cycle must not let a stale line hit.
    assign hit       = valid_q[idx] && (tag_mem[idx] == tag) && !flush;
    // Lines returned across a flush go to the CPU but are never marked valid.
    assign fill_keep = fill_we && !flush && !flush_seen_q;

    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= mem_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= 1'b0;
            addr_q       <= '0;
            flush_seen_q <= 1'b0;
            dout_q       <= '0;
            dtack_n_q    <= 1'b1;
            req_q        <= 1'b0;
            mem_addr_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= cpu_sel;
            addr_q       <= addr_d;
            flush_seen_q <= flush_seen_d;
            dout_q       <= dout_d;
            dtack_n_q    <= dtack_n_d;
            req_q        <= req_d;
            mem_addr_q   <= mem_addr_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (sel_rise) state_d = cpu_rw ? ST_LOOKUP : ST_ACK;
            // Never raise a new request until the previous ack has been seen low.
            ST_LOOKUP: begin
                if (hit)           state_d = ST_ACK;
                else if (!ack_s_q) state_d = ST_REQ;
            end
            ST_REQ:    if (ack_s_q) state_d = ST_REL;
            ST_REL:    if (!ack_s_q) state_d = cpu_sel ? ST_ACK : ST_IDLE;
            ST_ACK:    if (!cpu_sel) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        flush_seen_d = flush_seen_q;
        dout_d       = dout_q;
        dtack_n_d    = dtack_n_q;
        req_d        = req_q;
        mem_addr_d   = mem_addr_q;
        busy_d       = busy_q;
        fill_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_rise) begin
                    addr_d = cpu_addr;
                    if (!cpu_rw) dtack_n_d = 1'b0;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    dout_d    = pick_word(data_mem[idx], word);
                    dtack_n_d = 1'b0;
                end else if (!ack_s_q) begin
                    req_d        = 1'b1;
                    busy_d       = 1'b1;
                    mem_addr_d   = line_addr;
                    flush_seen_d = flush;
                end
            end
            ST_REQ: begin
                flush_seen_d = flush_seen_q || flush;
                if (ack_s_q) begin
                    fill_we = 1'b1;
                    req_d   = 1'b0;
                    dout_d  = pick_word(mem_data, word);
                end
            end
            ST_REL: begin
                if (!ack_s_q) begin
                    busy_d = 1'b0;
                    if (cpu_sel) dtack_n_d = 1'b0;
                end
            end
            ST_ACK: begin
                if (!cpu_sel) dtack_n_d = 1'b1;
            end
            default: begin
                dtack_n_d = 1'b1;
                req_d     = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge fixed_20m_clk) begin
        if (reset || flush) begin
            valid_q <= '0;
        end else if (fill_keep) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge fixed_20m_clk) begin
        if (fill_keep) begin
            data_mem[idx] <= mem_data;
            tag_mem[idx]  <= tag;
        end
    end

`ifdef PGM_ROMCACHE_STATS_EN
    logic        lookup_done;
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    // A stalled lookup is counted once, on the cycle it resolves.
    assign lookup_done = (state_q == ST_LOOKUP) && (hit || !ack_s_q);

    always_ff @(posedge fixed_20m_clk) begin
        if (reset || flush) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (lookup_done) begin
            if (hit) begin
                if (hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
            end else begin
                if (misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

    assign cpu_dout    = dout_q;
    assign cpu_dtack_n = dtack_n_q;
    assign mem_req     = req_q;
    assign mem_addr    = mem_addr_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pgm_rom_line_cache.sv
// Directed bench for pgm_rom_line_cache: a simple arbiter responder plus hand-computed read/write vectors.
module tb_pgm_rom_line_cache;

    logic        fixed_20m_clk = 1'b0;
    logic        reset;
    logic        cpu_sel;
    logic        cpu_rw;
    logic [22:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic        cpu_dtack_n;
    logic        flush;
    logic        mem_req;
    logic [20:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_data;
    logic        busy;
    logic [2:0]  dbg_state;
`ifdef PGM_ROMCACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          req_count = 0;
    logic [20:0] req_addr = '0;
    logic        busy_at_req = 1'b0;
    logic [63:0] resp_data = '0;
    logic        ack_at_dtack;
    logic        busy_at_dtack;
    logic [15:0] exp_q[$];

    pgm_rom_line_cache dut (
        .fixed_20m_clk (fixed_20m_clk),
        .reset         (reset),
        .cpu_sel       (cpu_sel),
        .cpu_rw        (cpu_rw),
        .cpu_addr      (cpu_addr),
        .cpu_dout      (cpu_dout),
        .cpu_dtack_n   (cpu_dtack_n),
        .flush         (flush),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .busy          (busy),
        .dbg_state_o   (dbg_state)
`ifdef PGM_ROMCACHE_STATS_EN
        ,
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses)
`endif
    );

    always #25 fixed_20m_clk = ~fixed_20m_clk;

    // Arbiter stand-in: ack a few cycles after req, release ack after req drops.
    initial begin
        mem_ack  = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge fixed_20m_clk);
            if (mem_req && !mem_ack) begin
                req_count   = req_count + 1;
                req_addr    = mem_addr;
                busy_at_req = busy;
                repeat (3) @(negedge fixed_20m_clk);
                mem_data = resp_data;
                mem_ack  = 1'b1;
                while (mem_req) @(negedge fixed_20m_clk);
                repeat (2) @(negedge fixed_20m_clk);
                mem_ack = 1'b0;
            end
        end
    end

    initial begin
        #(50 * 20000);
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: plain access, 1: drop cpu_sel once mem_req is seen, 2: pulse flush once mem_req is seen
    task automatic cpu_access(input logic rw, input logic [23:0] a, input int mode,
                              output logic [15:0] data, output int lat, output int reqs,
                              output logic acked);
        int req0;
        int guard;
        req0          = req_count;
        data          = '0;
        lat           = 0;
        acked         = 1'b0;
        ack_at_dtack  = 1'b1;
        busy_at_dtack = 1'b1;
        @(negedge fixed_20m_clk);
        cpu_addr = a[23:1];
        cpu_rw   = rw;
        cpu_sel  = 1'b1;
        if (mode != 0) begin
            guard = 0;
            while (!mem_req && guard < 100) begin
                @(negedge fixed_20m_clk);
                lat   = lat + 1;
                guard = guard + 1;
            end
            if (!mem_req) check_eq("req_wait_timeout", 64'd0, 64'd1);
            if (mode == 1) begin
                cpu_sel = 1'b0;
            end else begin
                flush = 1'b1;
                @(negedge fixed_20m_clk);
                lat   = lat + 1;
                flush = 1'b0;
            end
        end
        if (mode == 1) begin
            guard = 0;
            while ((busy || mem_ack) && guard < 200) begin
                @(negedge fixed_20m_clk);
                guard = guard + 1;
                if (!cpu_dtack_n) acked = 1'b1;
            end
            if (guard >= 200) check_eq("abort_timeout", 64'd0, 64'd1);
            repeat (3) begin
                @(negedge fixed_20m_clk);
                if (!cpu_dtack_n) acked = 1'b1;
            end
        end else begin
            while (cpu_dtack_n && lat < 200) begin
                @(negedge fixed_20m_clk);
                lat = lat + 1;
            end
            acked         = !cpu_dtack_n;
            data          = cpu_dout;
            ack_at_dtack  = mem_ack;
            busy_at_dtack = busy;
            cpu_sel       = 1'b0;
            @(negedge fixed_20m_clk);
            check_eq("dtack_release", {63'd0, cpu_dtack_n}, 64'd1);
        end
        reqs = req_count - req0;
        @(negedge fixed_20m_clk);
    endtask

    // exp_lat < 0 skips the latency check for miss paths.
    task automatic read_and_check(input string tag, input logic [23:0] a, input logic [15:0] exp_data,
                                  input int exp_reqs, input int exp_lat);
        logic [15:0] d;
        int          lat;
        int          reqs;
        logic        acked;
        exp_q.push_back(exp_data);
        cpu_access(1'b1, a, 0, d, lat, reqs, acked);
        check_eq({tag, "_dtack"}, {63'd0, acked}, 64'd1);
        check_eq({tag, "_data"}, {48'd0, d}, {48'd0, exp_q.pop_front()});
        check_eq({tag, "_reqs"}, reqs, exp_reqs);
        if (exp_lat >= 0) check_eq({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        logic [15:0] d;
        int          lat;
        int          reqs;
        logic        acked;

        reset    = 1'b1;
        cpu_sel  = 1'b0;
        cpu_rw   = 1'b1;
        cpu_addr = '0;
        flush    = 1'b0;
        repeat (3) @(negedge fixed_20m_clk);
        check_eq("rst_dtack_n", {63'd0, cpu_dtack_n}, 64'd1);
        check_eq("rst_dout", {48'd0, cpu_dout}, 64'd0);
        check_eq("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check_eq("rst_mem_addr", {43'd0, mem_addr}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge fixed_20m_clk);

        // Cold read: line 0x020000, word 2
        resp_data = 64'h4444_3333_2222_1111;
        read_and_check("cold", 24'h100004, 16'h3333, 1, -1);
        check_eq("cold_req_addr", {43'd0, req_addr}, 64'h020000);
        check_eq("cold_busy_at_req", {63'd0, busy_at_req}, 64'd1);
        check_eq("cold_ack_released", {63'd0, ack_at_dtack}, 64'd0);
        check_eq("cold_busy_at_dtack", {63'd0, busy_at_dtack}, 64'd0);

        read_and_check("reread", 24'h100006, 16'h4444, 0, 2);
        read_and_check("hit_w0", 24'h100000, 16'h1111, 0, 2);

        // Same index, different tag evicts and then misses back
        resp_data = 64'h8888_7777_6666_5555;
        read_and_check("conflict", 24'h100200, 16'h5555, 1, -1);
        check_eq("conflict_req_addr", {43'd0, req_addr}, 64'h020040);
        resp_data = 64'h4444_3333_2222_1111;
        read_and_check("conflict_back", 24'h100000, 16'h1111, 1, -1);
        check_eq("conflict_back_addr", {43'd0, req_addr}, 64'h020000);

        // Abort mid-fill: no DTACK, line still filled
        resp_data = 64'hDDDD_CCCC_BBBB_AAAA;
        cpu_access(1'b1, 24'h100010, 1, d, lat, reqs, acked);
        check_eq("abort_no_dtack", {63'd0, acked}, 64'd0);
        check_eq("abort_reqs", reqs, 1);
        check_eq("abort_req_addr", {43'd0, req_addr}, 64'h020002);
        read_and_check("abort_hit", 24'h100012, 16'hBBBB, 0, 2);

        // Write: DTACK at N+1, no fill, cache untouched
        cpu_access(1'b0, 24'h000010, 0, d, lat, reqs, acked);
        check_eq("write_dtack", {63'd0, acked}, 64'd1);
        check_eq("write_lat", lat, 1);
        check_eq("write_reqs", reqs, 0);
        read_and_check("after_write", 24'h100014, 16'hCCCC, 0, 2);

        // Flush while waiting for ack: data delivered, line not kept
        resp_data = 64'h1234_5678_9ABC_DEF0;
        cpu_access(1'b1, 24'h100018, 2, d, lat, reqs, acked);
        check_eq("flush_fill_dtack", {63'd0, acked}, 64'd1);
        check_eq("flush_fill_data", {48'd0, d}, 64'hDEF0);
        check_eq("flush_fill_reqs", reqs, 1);
        read_and_check("flush_reread", 24'h10001A, 16'h9ABC, 1, -1);
        resp_data = 64'h4444_3333_2222_1111;
        read_and_check("flush_old_line", 24'h100006, 16'h4444, 1, -1);
        read_and_check("refill_hit", 24'h100004, 16'h3333, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
